btn_cmd_scheduler: RTL and testbench

Collects one-cycle button events from four debounce/edge-detector instances and turns them into an ordered stream of 8-bit commands for a single downstream consumer, such as the SPI master TX path or the counter control. Each button has a pending-request latch. Grants rotate round-robin so no button starves. Commands leave over a valid/ready handshake, and a programmable holdoff gap follows every accepted command.

---
 rtl/btn_cmd_scheduler.sv | 72 +++++++
 tb/tb_btn_cmd_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_scheduler.sv
// btn_cmd_scheduler: round-robin arbiter turning button pulses into a gapped valid/ready command stream
module btn_cmd_scheduler #(
  parameter int GAP_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_pulse,
  input  logic       cmd_ready,
  input  logic       ovf_clr,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic [3:0] pending,
  output logic       busy,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] grant_id;
  logic [1:0] gnt;
  logic [5:0] seq;
  logic [7:0] gap_cnt;
  logic       accept;
  logic [3:0] clr_mask;
  logic [3:0] keep;
  assign accept   = cmd_valid && cmd_ready;
  assign clr_mask = accept ? 4'(4'b0001 << grant_id) : 4'b0000;
  assign keep     = pending & ~clr_mask;
  assign busy     = state != IDLE;
  // descending walk so the first pending index at or after rr_ptr wins
  always_comb begin
    gnt = rr_ptr;
    for (int k = 3; k >= 0; k--)
      if (pending[2'(rr_ptr + 2'(k))]) gnt = 2'(rr_ptr + 2'(k));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      seq       <= '0;
      gap_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      pending  <= keep | btn_pulse;
      overflow <= |(btn_pulse & keep) || (overflow && !ovf_clr);
      case (state)
        IDLE: if (|pending) begin
          grant_id  <= gnt;
          cmd_data  <= {gnt, seq};
          cmd_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          seq       <= seq + 6'd1;
          rr_ptr    <= grant_id + 2'd1;
          gap_cnt   <= 8'(GAP_CYC);
          state     <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// tb_btn_cmd_scheduler: directed scenario bench for btn_cmd_scheduler
module tb_btn_cmd_scheduler;
  localparam int G = 16;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       cmd_ready;
  logic       ovf_clr;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic [3:0] pending;
  logic       busy;
  logic       overflow;
  int passed = 0;
  int total = 0;
  int cyc = 0;

  btn_cmd_scheduler #(.GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .pending(pending), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    btn_pulse = 4'b0;
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_pulse = 4'b0;
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    total++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", cmd_valid); else passed++;
    total++; if (cmd_data !== 8'h00) $display("FAIL reset_data got %h exp 00", cmd_data); else passed++;
    total++; if (pending !== 4'b0) $display("FAIL reset_pending got %b exp 0000", pending); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int low = 0;
    do_reset();
    cmd_ready = 1'b1;
    btn_pulse = 4'b0100;
    tick();
    btn_pulse = 4'b0;
    total++; if (pending !== 4'b0100 || cmd_valid !== 1'b0) $display("FAIL single_latch got pend %b valid %b exp 0100 0", pending, cmd_valid); else passed++;
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd_data !== 8'h80) $display("FAIL single_issue got valid %b data %h exp 1 80", cmd_valid, cmd_data); else passed++;
    tick();
    total++; if (cmd_valid !== 1'b0 || pending !== 4'b0 || busy !== 1'b1) $display("FAIL single_accept got valid %b pend %b busy %b exp 0 0000 1", cmd_valid, pending, busy); else passed++;
    for (int i = 1; i < G; i++) begin
      tick();
      if (busy !== 1'b1) low++;
    end
    total++; if (low !== 0) $display("FAIL single_gap_busy got %0d low cycles exp 0", low); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL single_gap_end got busy %b exp 0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rr [4] = '{8'h00, 8'h41, 8'h82, 8'hC3};
    int rise [4];
    bit ok;
    do_reset();
    cmd_ready = 1'b1;
    btn_pulse = 4'b1111;
    tick();
    btn_pulse = 4'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      rise[k] = cyc;
      total++; if (!ok || cmd_data !== exp_rr[k]) $display("FAIL rr_data%0d got valid %b data %h exp 1 %h", k, ok, cmd_data, exp_rr[k]); else passed++;
      if (k > 0) begin
        total++; if (rise[k] - rise[k-1] !== G + 2) $display("FAIL rr_period%0d got %0d exp %0d", k, rise[k] - rise[k-1], G + 2); else passed++;
      end
      tick();
    end
    settle();
    btn_pulse = 4'b0011;
    tick();
    btn_pulse = 4'b0;
    wait_valid(ok);
    total++; if (!ok || cmd_data !== 8'h04) $display("FAIL rr_second0 got valid %b data %h exp 1 04", ok, cmd_data); else passed++;
    tick();
    wait_valid(ok);
    total++; if (!ok || cmd_data !== 8'h45) $display("FAIL rr_second1 got valid %b data %h exp 1 45", ok, cmd_data); else passed++;
    tick();
    settle();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bit ok;
    do_reset();
    btn_pulse = 4'b0010;
    tick();
    btn_pulse = 4'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      btn_pulse = (i == 5) ? 4'b1000 : 4'b0000;
      if (cmd_valid !== 1'b1 || cmd_data !== 8'h40) bad++;
      tick();
    end
    btn_pulse = 4'b0;
    total++; if (bad !== 0 || cmd_data !== 8'h40) $display("FAIL bp_hold got %0d bad cycles data %h exp 0 40", bad, cmd_data); else passed++;
    total++; if (pending !== 4'b1010) $display("FAIL bp_pending got %b exp 1010", pending); else passed++;
    cmd_ready = 1'b1;
    tick();
    total++; if (cmd_valid !== 1'b0 || pending !== 4'b1000) $display("FAIL bp_accept got valid %b pend %b exp 0 1000", cmd_valid, pending); else passed++;
    wait_valid(ok);
    total++; if (!ok || cmd_data !== 8'hC1) $display("FAIL bp_next got valid %b data %h exp 1 c1", ok, cmd_data); else passed++;
    tick();
    settle();
  endtask

  task automatic test_overflow();
    int extra = 0;
    do_reset();
    btn_pulse = 4'b0001;
    tick();
    btn_pulse = 4'b0;
    tick();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_quiet got %b exp 0", overflow); else passed++;
    btn_pulse = 4'b0001;
    tick();
    btn_pulse = 4'b0;
    total++; if (overflow !== 1'b1 || pending !== 4'b0001) $display("FAIL ovf_set got ovf %b pend %b exp 1 0001", overflow, pending); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else passed++;
    ovf_clr = 1'b1;
    btn_pulse = 4'b0001;
    tick();
    ovf_clr = 1'b0;
    btn_pulse = 4'b0;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", overflow); else passed++;
    total++; if (cmd_valid !== 1'b1 || cmd_data !== 8'h00) $display("FAIL ovf_cmd got valid %b data %h exp 1 00", cmd_valid, cmd_data); else passed++;
    cmd_ready = 1'b1;
    tick();
    for (int i = 0; i < G + 6; i++) begin
      if (cmd_valid) extra++;
      tick();
    end
    total++; if (extra !== 0 || pending !== 4'b0) $display("FAIL ovf_single_cmd got %0d extra valid cycles pend %b exp 0 0000", extra, pending); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passed++;
  endtask

  task automatic test_coincident_and_wrap();
    int bad = 0;
    bit ok;
    do_reset();
    btn_pulse = 4'b0100;
    tick();
    btn_pulse = 4'b0;
    tick();
    btn_pulse = 4'b0100;
    cmd_ready = 1'b1;
    tick();
    btn_pulse = 4'b0;
    total++; if (pending !== 4'b0100 || overflow !== 1'b0 || cmd_valid !== 1'b0) $display("FAIL coin_accept got pend %b ovf %b valid %b exp 0100 0 0", pending, overflow, cmd_valid); else passed++;
    wait_valid(ok);
    total++; if (!ok || cmd_data !== 8'h81) $display("FAIL coin_second got valid %b data %h exp 1 81", ok, cmd_data); else passed++;
    tick();
    settle();
    do_reset();
    cmd_ready = 1'b1;
    for (int n = 0; n <= 64; n++) begin
      btn_pulse = 4'b0100;
      tick();
      btn_pulse = 4'b0;
      wait_valid(ok);
      if (!ok || cmd_data !== {2'd2, 6'(n)}) bad++;
      if (n == 63) begin
        total++; if (cmd_data !== 8'hBF) $display("FAIL wrap_63 got %h exp bf", cmd_data); else passed++;
      end
      if (n == 64) begin
        total++; if (cmd_data !== 8'h80) $display("FAIL wrap_0 got %h exp 80", cmd_data); else passed++;
      end
      tick();
      settle();
    end
    total++; if (bad !== 0) $display("FAIL wrap_seq got %0d bad commands exp 0", bad); else passed++;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    btn_pulse = 4'b0010;
    tick();
    btn_pulse = 4'b0;
    tick();
    btn_pulse = 4'b1010;
    tick();
    btn_pulse = 4'b0;
    total++; if (cmd_valid !== 1'b1 || pending !== 4'b1010 || overflow !== 1'b1) $display("FAIL ar_setup got valid %b pend %b ovf %b exp 1 1010 1", cmd_valid, pending, overflow); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (cmd_valid !== 1'b0 || pending !== 4'b0 || busy !== 1'b0 || overflow !== 1'b0) $display("FAIL ar_clear got valid %b pend %b busy %b ovf %b exp 0 0000 0 0", cmd_valid, pending, busy, overflow); else passed++;
    tick();
    rst = 1'b0;
    cmd_ready = 1'b1;
    btn_pulse = 4'b0001;
    tick();
    btn_pulse = 4'b0;
    wait_valid(ok);
    total++; if (!ok || cmd_data !== 8'h00) $display("FAIL ar_seq0 got valid %b data %h exp 1 00", ok, cmd_data); else passed++;
    tick();
    settle();
  endtask

  initial begin
    rst = 1'b1;
    btn_pulse = 4'b0;
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_coincident_and_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
